// File: rtl/collision_detect_if.sv
// -----------------------------------------------------------------------------
// collision_detect_if
// Bullet-table access bundle between the collision tester and the bullet table.
//   bullet_addr   : table read address (driven by the tester)
//   bullet_valid  : read data, entry is live (one cycle after the address)
//   bullet_x/y    : read data, entry centre coordinates
//   clr_en        : one-cycle request to invalidate entry clr_addr
//   clr_addr      : index of the entry to invalidate
// Modports:
//   master : the collision tester (drives address and clear requests)
//   slave  : the bullet table (returns read data, accepts clear requests)
// -----------------------------------------------------------------------------
interface collision_detect_if #(
    parameter int ADDR_W  = 6,
    parameter int COORD_W = 10
);
    logic [ADDR_W-1:0]  bullet_addr;
    logic               bullet_valid;
    logic [COORD_W-1:0] bullet_x;
    logic [COORD_W-1:0] bullet_y;
    logic               clr_en;
    logic [ADDR_W-1:0]  clr_addr;

    modport master (
        output bullet_addr,
        output clr_en,
        output clr_addr,
        input  bullet_valid,
        input  bullet_x,
        input  bullet_y
    );

    modport slave (
        input  bullet_addr,
        input  clr_en,
        input  clr_addr,
        output bullet_valid,
        output bullet_x,
        output bullet_y
    );
endinterface

// File: rtl/collision_detect.sv
// -----------------------------------------------------------------------------
// collision_detect
// Once per frame, sweeps the bullet table and tests each live bullet against
// the player hitbox. In hit mode the lowest hitting index is reported in a
// single REPORT cycle (collision pulse plus a clear request for that entry).
// In bomb mode every live entry gets a clear request as its data returns and
// no collision is ever reported.
// Ports:
//   clk          : system clock
//   hard_reset_n : asynchronous active-low reset
//   frame_tick   : one-cycle sweep request
//   game_en      : game running; dropping it aborts a sweep
//   game_state   : FSM state code (Play = 5'b00010, Bomb = 5'b00110)
//   player_x/y   : player hitbox centre, held stable during a sweep
//   tbl          : bullet table read port and clear request (master side)
//   collision    : one-cycle hit pulse
//   hit_index    : index of the last reported hit, held between reports
//   busy         : sweep in progress
//   overrun      : sticky, a frame_tick arrived while busy
// -----------------------------------------------------------------------------
module collision_detect #(
    parameter int NUM_BULLETS = 64,
    parameter int ADDR_W      = 6,
    parameter int COORD_W     = 10,
    parameter int HIT_R       = 3,
    parameter int BULLET_R    = 2
) (
    input  logic               clk,
    input  logic               hard_reset_n,
    input  logic               frame_tick,
    input  logic               game_en,
    input  logic [4:0]         game_state,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    collision_detect_if.master tbl,
    output logic               collision,
    output logic [ADDR_W-1:0]  hit_index,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_REPORT
    } state_t;

    localparam logic [4:0]                GS_PLAY   = 5'b00010;
    localparam logic [4:0]                GS_BOMB   = 5'b00110;
    localparam logic [ADDR_W-1:0]         LAST_ADDR = ADDR_W'(NUM_BULLETS - 1);
    localparam int                        REACH_I   = HIT_R + BULLET_R;
    localparam logic signed [COORD_W:0]   REACH     = (COORD_W + 1)'(REACH_I);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   bullet_addr_q;
    logic [ADDR_W-1:0]   eval_addr_q;   // index whose data is on the bus this cycle
    logic                eval_q;        // read data on the bus belongs to this sweep
    logic                bomb_q;        // sweep mode latched at accept
    logic                found_q;
    logic [ADDR_W-1:0]   win_q;
    logic                collision_q;
    logic                rpt_clr_q;
    logic [ADDR_W-1:0]   rpt_addr_q;
    logic [ADDR_W-1:0]   hit_index_q;
    logic                busy_q;
    logic                overrun_q;

    logic                accept;
    logic signed [COORD_W:0] dx, dy;
    logic                in_box;
    logic                hit_now;
    logic                bomb_clr;
    logic                found_any;
    logic [ADDR_W-1:0]   win_addr;

    assign accept = frame_tick && game_en &&
                    ((game_state == GS_PLAY) || (game_state == GS_BOMB));

    // One extra bit keeps the differences exact across the whole coordinate range.
    assign dx = $signed({1'b0, tbl.bullet_x}) - $signed({1'b0, player_x});
    assign dy = $signed({1'b0, tbl.bullet_y}) - $signed({1'b0, player_y});

    assign in_box = tbl.bullet_valid &&
                    (dx <= REACH) && (dx >= -REACH) &&
                    (dy <= REACH) && (dy >= -REACH);

    assign hit_now   = eval_q && !bomb_q && in_box;
    assign bomb_clr  = eval_q && bomb_q && tbl.bullet_valid;
    assign found_any = found_q || hit_now;
    assign win_addr  = found_q ? win_q : eval_addr_q;

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SCAN;
            S_SCAN:   if (bullet_addr_q == LAST_ADDR) state_d = S_FLUSH;
            S_FLUSH:  state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && !game_en) state_d = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q       <= S_IDLE;
            bullet_addr_q <= '0;
            eval_addr_q   <= '0;
            eval_q        <= 1'b0;
            bomb_q        <= 1'b0;
            found_q       <= 1'b0;
            win_q         <= '0;
            collision_q   <= 1'b0;
            rpt_clr_q     <= 1'b0;
            rpt_addr_q    <= '0;
            hit_index_q   <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            eval_addr_q <= bullet_addr_q;
            // Data for the address issued in SCAN returns next cycle, unless aborting.
            eval_q      <= (state_q == S_SCAN) && (state_d != S_IDLE);

            if (state_d == S_IDLE)
                bullet_addr_q <= '0;
            else if ((state_q == S_SCAN) && (state_d == S_SCAN))
                bullet_addr_q <= bullet_addr_q + 1'b1;

            if ((state_q == S_IDLE) && (state_d == S_SCAN)) begin
                bomb_q  <= (game_state == GS_BOMB);
                found_q <= 1'b0;
            end else if (hit_now && !found_q) begin
                found_q <= 1'b1;
                win_q   <= eval_addr_q;
            end

            // The last entry is evaluated in FLUSH, so fold in a same-cycle hit.
            collision_q <= 1'b0;
            rpt_clr_q   <= 1'b0;
            rpt_addr_q  <= '0;
            if ((state_q == S_FLUSH) && (state_d == S_REPORT) && !bomb_q && found_any) begin
                collision_q <= 1'b1;
                rpt_clr_q   <= 1'b1;
                rpt_addr_q  <= win_addr;
                hit_index_q <= win_addr;
            end

            if (frame_tick && busy_q) overrun_q <= 1'b1;
        end
    end

    // Bomb clears must land in the same cycle the entry's data returns, so they
    // bypass the report registers; eval_q gates them off in IDLE and on reset.
    assign tbl.bullet_addr = bullet_addr_q;
    assign tbl.clr_en      = rpt_clr_q || bomb_clr;
    assign tbl.clr_addr    = bomb_clr ? eval_addr_q : rpt_addr_q;

    assign collision = collision_q;
    assign hit_index = hit_index_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_collision_detect.sv
// -----------------------------------------------------------------------------
// tb_collision_detect
// Self-checking bench for collision_detect: table-driven hitbox cases, hand
// sequences for multi-hit, bomb, gating, overrun, abort and reset, and random
// sweeps checked against a behavioural model of the sweep.
// -----------------------------------------------------------------------------
module tb_collision_detect;

    localparam int NB = 64;
    localparam int AW = 6;
    localparam int CW = 10;
    localparam int REACH = 5;
    localparam logic [4:0] GS_PLAY = 5'b00010;
    localparam logic [4:0] GS_BOMB = 5'b00110;

    logic          clk = 1'b0;
    logic          hard_reset_n;
    logic          frame_tick;
    logic          game_en;
    logic [4:0]    game_state;
    logic [CW-1:0] player_x, player_y;
    logic          collision, busy, overrun;
    logic [AW-1:0] hit_index;

    collision_detect_if #(.ADDR_W(AW), .COORD_W(CW)) tbl_if ();

    collision_detect #(
        .NUM_BULLETS(NB), .ADDR_W(AW), .COORD_W(CW), .HIT_R(3), .BULLET_R(2)
    ) dut (
        .clk(clk), .hard_reset_n(hard_reset_n), .frame_tick(frame_tick),
        .game_en(game_en), .game_state(game_state),
        .player_x(player_x), .player_y(player_y), .tbl(tbl_if),
        .collision(collision), .hit_index(hit_index), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Bullet table: synchronous read, contents fixed during each sweep.
    bit            tv [NB];
    logic [CW-1:0] tx [NB];
    logic [CW-1:0] ty [NB];

    always @(posedge clk) begin
        tbl_if.bullet_valid <= tv[tbl_if.bullet_addr];
        tbl_if.bullet_x     <= tx[tbl_if.bullet_addr];
        tbl_if.bullet_y     <= ty[tbl_if.bullet_addr];
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] exp_hit_index;
    bit            exp_ovr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {overrun, busy, addr, collision, clr_en, clr_addr (when clr_en), hit_index}
    function automatic logic [63:0] pack(input logic ovr, input logic bsy, input logic [AW-1:0] addr,
                                         input logic col, input logic clr, input logic [AW-1:0] caddr,
                                         input logic [AW-1:0] hidx);
        logic [AW-1:0] ca;
        ca = clr ? caddr : '0;
        return 64'({ovr, bsy, addr, col, clr, ca, hidx});
    endfunction

    function automatic logic [63:0] observe();
        return pack(overrun, busy, tbl_if.bullet_addr, collision, tbl_if.clr_en,
                    tbl_if.clr_addr, hit_index);
    endfunction

    task automatic clear_table();
        for (int i = 0; i < NB; i++) begin
            tv[i] = 1'b0;
            tx[i] = '0;
            ty[i] = '0;
        end
    endtask

    task automatic place(input int idx, input int x, input int y);
        tv[idx] = 1'b1;
        tx[idx] = CW'(x);
        ty[idx] = CW'(y);
    endtask

    // Reference: lowest live entry within REACH on both axes, or -1.
    function automatic int expected_hit();
        for (int i = 0; i < NB; i++) begin
            int dx, dy;
            dx = int'(tx[i]) - int'(player_x);
            dy = int'(ty[i]) - int'(player_y);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (tv[i] && dx <= REACH && dy <= REACH) return i;
        end
        return -1;
    endfunction

    // Issues a tick at the current negedge, then checks cycles T+1..T+NB+3.
    // tick2_n / abort_n (0 = unused): extra tick or game_en drop after cycle n.
    task automatic run_sweep(input bit bomb, input int tick2_n, input int abort_n,
                             input string tag, output int n_col, output logic [AW-1:0] last_hidx);
        int            hit;
        bit            live, e_busy, e_col, e_clr;
        logic [AW-1:0] e_addr, e_caddr;
        hit        = bomb ? -1 : expected_hit();
        game_state = bomb ? GS_BOMB : GS_PLAY;
        game_en    = 1'b1;
        frame_tick = 1'b1;
        n_col      = 0;
        for (int n = 1; n <= NB + 3; n++) begin
            @(negedge clk);
            live    = (abort_n == 0) || (n <= abort_n);
            e_busy  = live && (n <= NB + 2);
            e_addr  = (!live || n > NB + 2) ? '0 : ((n <= NB) ? AW'(n - 1) : AW'(NB - 1));
            e_col   = 1'b0;
            e_clr   = 1'b0;
            e_caddr = '0;
            if (live && bomb && n >= 2 && n <= NB + 1 && tv[n - 2]) begin
                e_clr   = 1'b1;
                e_caddr = AW'(n - 2);
            end
            if (live && !bomb && n == NB + 2 && hit >= 0) begin
                e_col         = 1'b1;
                e_clr         = 1'b1;
                e_caddr       = AW'(hit);
                exp_hit_index = AW'(hit);
            end
            if (tick2_n != 0 && n == tick2_n + 1) exp_ovr = 1'b1;
            check($sformatf("%s cyc T+%0d", tag, n), observe(),
                  pack(exp_ovr, e_busy, e_addr, e_col, e_clr, e_caddr, exp_hit_index));
            n_col += int'(collision);
            frame_tick = (n == tick2_n);
            if (n == abort_n) game_en = 1'b0;
        end
        frame_tick = 1'b0;
        game_en    = 1'b1;
        last_hidx  = hit_index;
    endtask

    typedef struct {
        int px, py, idx, bx, by;
        bit hit;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[8];
        int            n_col;
        logic [AW-1:0] hidx;

        vecs[0] = '{100, 100,  5,  102,   99, 1'b1};
        vecs[1] = '{100, 100,  3,  105,  100, 1'b1};
        vecs[2] = '{100, 100,  3,  106,  100, 1'b0};
        vecs[3] = '{100, 100,  3,   95,   95, 1'b1};
        vecs[4] = '{  0,   0,  3, 1023,    0, 1'b0};
        vecs[5] = '{100, 100, 63,  100,  105, 1'b1};
        vecs[6] = '{1023, 1023, 0, 1018, 1023, 1'b1};
        vecs[7] = '{100, 100, 10,  100,   94, 1'b0};

        hard_reset_n  = 1'b0;
        frame_tick    = 1'b0;
        game_en       = 1'b0;
        game_state    = '0;
        player_x      = '0;
        player_y      = '0;
        exp_hit_index = '0;
        exp_ovr       = 1'b0;
        clear_table();

        repeat (2) @(negedge clk);
        check("reset held", observe(), pack(0, 0, 0, 0, 0, 0, 0));
        hard_reset_n = 1'b1;
        @(negedge clk);
        check("after reset idle", observe(), pack(0, 0, 0, 0, 0, 0, 0));

        // Hitbox cases, back-to-back so each tick lands in the first IDLE cycle.
        foreach (vecs[v]) begin
            clear_table();
            player_x = CW'(vecs[v].px);
            player_y = CW'(vecs[v].py);
            place(vecs[v].idx, vecs[v].bx, vecs[v].by);
            run_sweep(1'b0, 0, 0, $sformatf("vec%0d", v), n_col, hidx);
            check($sformatf("vec%0d collision count", v), 64'(n_col), 64'(vecs[v].hit ? 1 : 0));
            if (vecs[v].hit) check($sformatf("vec%0d hit_index", v), 64'(hidx), 64'(vecs[v].idx));
        end

        // Two hits in one sweep: lowest index wins, single pulse.
        clear_table();
        player_x = 10'd100;
        player_y = 10'd100;
        place(9, 101, 101);
        place(2, 99, 100);
        run_sweep(1'b0, 0, 0, "multi", n_col, hidx);
        check("multi collision count", 64'(n_col), 64'd1);
        check("multi hit_index", 64'(hidx), 64'd2);

        // Bomb: clears for entries 0, 7, 63; entry 7 sits on the player.
        clear_table();
        place(0, 500, 500);
        place(7, 100, 100);
        place(63, 20, 900);
        run_sweep(1'b1, 0, 0, "bomb", n_col, hidx);
        check("bomb collision count", 64'(n_col), 64'd0);

        // Gating: disabled game, or a state other than Play/Bomb.
        game_en    = 1'b0;
        game_state = GS_PLAY;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("gate game_en=0 busy c%0d", i), 64'(busy), 64'd0);
            @(negedge clk);
        end
        game_en    = 1'b1;
        game_state = 5'b00001;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("gate state busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("gate state busy later", 64'(busy), 64'd0);

        // Overrun: second tick at T+10, first sweep still completes.
        clear_table();
        place(5, 102, 99);
        run_sweep(1'b0, 10, 0, "overrun", n_col, hidx);
        check("overrun collision count", 64'(n_col), 64'd1);

        // Abort with a hit pending at entry 30.
        clear_table();
        place(30, 103, 103);
        run_sweep(1'b0, 0, 20, "abort", n_col, hidx);
        check("abort collision count", 64'(n_col), 64'd0);
        check("abort hit_index", 64'(hidx), 64'd5);

        // Random sweeps against the model.
        for (int r = 0; r < 12; r++) begin
            bit bomb;
            player_x = CW'($urandom_range(0, 1023));
            player_y = CW'($urandom_range(0, 1023));
            for (int i = 0; i < NB; i++) begin
                int x, y;
                tv[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    x = int'(player_x) + int'($urandom_range(0, 14)) - 7;
                    y = int'(player_y) + int'($urandom_range(0, 14)) - 7;
                end else begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end
                x = (x < 0) ? 0 : ((x > 1023) ? 1023 : x);
                y = (y < 0) ? 0 : ((y > 1023) ? 1023 : y);
                tx[i] = CW'(x);
                ty[i] = CW'(y);
            end
            bomb = ($urandom_range(0, 2) == 0);
            run_sweep(bomb, 0, 0, $sformatf("rand%0d", r), n_col, hidx);
        end

        // Asynchronous reset in the middle of a bomb sweep over a full table.
        for (int i = 0; i < NB; i++) place(i, i * 3, i * 5);
        game_state = GS_BOMB;
        game_en    = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (29) @(negedge clk);
        check("pre-reset overrun", 64'(overrun), 64'd1);
        check("pre-reset clr_en", 64'(tbl_if.clr_en), 64'd1);
        hard_reset_n = 1'b0;
        #1;
        check("mid-sweep reset outputs", observe(), pack(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        hard_reset_n  = 1'b1;
        exp_ovr       = 1'b0;
        exp_hit_index = '0;
        @(negedge clk);
        check("post-reset idle", observe(), pack(0, 0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_detect.md
# collision_detect

Per-frame hit tester that produces the `collision` pulse consumed by the game control FSM. Once per frame it sweeps the bullet table through a synchronous read port and compares each live bullet against the player hitbox. It reports at most one hit per frame and requests removal of the hit bullet. While the FSM is in the Bomb state, the same sweep instead clears every live bullet.

## Interface
Parameters:
- `NUM_BULLETS`, 64: bullet table depth; must be a power of two.
- `ADDR_W`, 6: equals log2(`NUM_BULLETS`).
- `COORD_W`, 10: unsigned pixel coordinate width.
- `HIT_R`, 3: player hitbox half-size in pixels.
- `BULLET_R`, 2: bullet half-size in pixels.

Ports:
- `clk`  in  1  system clock. This is the only clock.
- `hard_reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse requesting a sweep.
- `game_en`  in  1  game running, from the FSM.
- `game_state`  in  5  FSM state code. Play = 5'b00010, Bomb = 5'b00110.
- `player_x`, `player_y`  in  `COORD_W`  player hitbox centre.
- `bullet_addr`  out  `ADDR_W`  table read address.
- `bullet_valid`, `bullet_x`, `bullet_y`  in  1/`COORD_W`/`COORD_W`  table read data. Data arrives one cycle after the address.
- `collision`  out  1  one-cycle hit pulse to the FSM.
- `hit_index`  out  `ADDR_W`  index of the last reported hit. Holds its value between reports.
- `clr_en`, `clr_addr`  out  1/`ADDR_W`  one-cycle request to invalidate a table entry.
- `busy`  out  1  a sweep is in progress.
- `overrun`  out  1  sticky flag: a `frame_tick` arrived while `busy` was high.

## Operation
- States:
  - IDLE: waits for a sweep request.
  - SCAN: issues addresses 0..`NUM_BULLETS`-1, one per cycle.
  - FLUSH: one cycle to evaluate the data for the last address.
  - REPORT: one cycle that emits the result.
- Accept condition: `frame_tick` in IDLE with `game_en`=1 and `game_state` equal to Play or Bomb. Any other `frame_tick` in IDLE is ignored. The mode (hit or bomb) is latched at accept.
- Hit test, applied to data that returns while a sweep is active:
  - Condition: `bullet_valid`=1, |`bullet_x`−`player_x`| ≤ `HIT_R`+`BULLET_R`, and |`bullet_y`−`player_y`| ≤ `HIT_R`+`BULLET_R`.
  - Differences are computed at `COORD_W`+1 bits signed, so there is no wrap-around; the maximum difference is correct.
  - The lowest hitting index wins. Later hits in the same sweep are ignored.
- Hit mode, REPORT state:
  - If a hit was found: `collision`=1, `clr_en`=1, `clr_addr`=`hit_index`=winning index.
  - If no hit was found: all three outputs stay 0.
- Bomb mode:
  - For every returned entry with `bullet_valid`=1, assert `clr_en`=1 with `clr_addr` equal to that entry's index, in the same cycle its data returns.
  - `collision` is never asserted in bomb mode. REPORT is silent.
- Abort: if `game_en` drops during SCAN, FLUSH or REPORT, return to IDLE on the next edge.
  - After abort, `busy`, `collision` and `clr_en` are 0.
  - `hit_index` is unchanged.
- Overrun: `frame_tick` while `busy`=1 sets `overrun`=1. The tick is otherwise ignored. `overrun` clears only on reset.
- Reset (asynchronous, any time, including mid-sweep):
  - State returns to IDLE.
  - All outputs go to 0: `bullet_addr`, `collision`, `hit_index`, `clr_en`, `clr_addr`, `busy`, `overrun`.
- `player_x` and `player_y` are sampled live. The owner holds them stable for the duration of a sweep.

## Timing
- Let `frame_tick` be accepted at edge T.
- `busy`=1 and `bullet_addr`=0 from T+1.
- `bullet_addr`=k during cycle T+1+k. Its data is evaluated in cycle T+2+k.
- FLUSH is cycle T+1+`NUM_BULLETS`. REPORT is cycle T+2+`NUM_BULLETS`.
- `busy` falls at T+3+`NUM_BULLETS`. With the default parameters: REPORT at T+66, IDLE at T+67.
- `bullet_addr` holds `NUM_BULLETS`−1 during FLUSH and REPORT, and returns to 0 in IDLE.
- All outputs are registered. `collision` and `clr_en` are exactly one cycle wide per event.
- A new `frame_tick` can be accepted in the first IDLE cycle.

## Test plan
- Hit mode, direct hit: player (100,100); entry 5 valid at (102,99); all other entries invalid. Tick → `collision`=1, `clr_en`=1, `clr_addr`=5, `hit_index`=5, all in cycle T+66; `busy` low at T+67.
- Hitbox edge cases:
  - Entry 3 at (105,100): distance exactly 5, so a hit.
  - Entry 3 at (106,100): distance 6, so no collision.
  - Entry 3 at (95,95) with player (100,100): a hit.
  - Player (0,0), bullet (1023,0): no hit (no wrap-around).
- Multiple hits: entries 9 and 2 both hit → exactly one `collision` pulse, with `hit_index`=2.
- Bomb mode: `game_state`=00110; entries 0, 7 and 63 valid. Tick → `clr_en` pulses at T+2, T+9 and T+65 with addresses 0, 7 and 63; `collision` is never 1.
- Gating and overrun:
  - Tick with `game_en`=0 → `busy` stays 0.
  - Second tick at T+10 → `overrun`=1, and the first sweep completes normally.
- Abort and reset:
  - `game_en` dropped at T+20 with a hit pending → no `collision`; IDLE at T+21.
  - `hard_reset_n` pulsed low mid-sweep → all outputs read 0 immediately, including `overrun`.
